pll_phase_ctrl: RTL and testbench

- Drives the ECP5 EHXPLLL dynamic phase-adjust pins (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG) from a request handshake.
- Monitors the PLL LOCK output and reports a debounced ready.
- Sits next to the board PLL wrapper; user logic (e.g. SDRAM/DDR capture tuning) requests N fine phase steps on one PLL output.

---
 rtl/pll_phase_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 43 ++++
 rtl/pll_phase_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 dynamic phase-adjust controller.
package pll_phase_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      PULSE  = 3'd2,
      GAP    = 3'd3,
      RELOCK = 3'd4,
      ZERO   = 3'd5,
      FINISH = 3'd6
   } state_t;

   // PHASESEL encodings of the EHXPLLL outputs.
   localparam logic [1:0] SEL_CLKOS  = 2'b00;
   localparam logic [1:0] SEL_CLKOS2 = 2'b01;
   localparam logic [1:0] SEL_CLKOS3 = 2'b10;
   localparam logic [1:0] SEL_CLKOP  = 2'b11;

   localparam logic DIR_DELAY   = 1'b0;
   localparam logic DIR_ADVANCE = 1'b1;

   function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Synchronises the raw PLL LOCK and reports ready once it has been stable
// for LOCK_SETTLE consecutive control-clock cycles.
module pll_lock_sync #(
   parameter int unsigned LOCK_SETTLE = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pll_locked,
   output logic pll_ready
);

   localparam int unsigned CNT_W = (LOCK_SETTLE < 1) ? 1 : $clog2(LOCK_SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LOCK_SETTLE);

   logic             lock_meta;
   logic             lock_sync;
   logic [CNT_W-1:0] settle_cnt;

   // Two-flop synchroniser; LOCK is asynchronous to the control clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_sync <= lock_meta;
      end
   end

   // Saturating settle counter; any synced unlock restarts the qualification.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         settle_cnt <= '0;
      end else if (!lock_sync) begin
         settle_cnt <= '0;
      end else if (settle_cnt != CNT_SAT) begin
         settle_cnt <= settle_cnt + CNT_W'(1);
      end
   end

   assign pll_ready = (settle_cnt == CNT_SAT);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Request-driven stepper for the ECP5 EHXPLLL dynamic phase-adjust pins.
//
//   state  | meaning
//   IDLE   | waiting for a request; sel/dir hold the previous request
//   SETUP  | sel/dir settling before the first PHASESTEP pulse
//   PULSE  | PHASESTEP driven low
//   GAP    | PHASESTEP high between pulses; step count decremented at end
//   RELOCK | all steps issued, waiting for pll_ready or timeout
//   ZERO   | zero-step request, nothing to issue
//   FINISH | done pulse, err valid
module pll_phase_ctrl
   import pll_phase_pkg::*;
#(
   parameter int unsigned STEP_W      = 8,
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned PULSE_CYC   = 2,
   parameter int unsigned GAP_CYC     = 4,
   parameter int unsigned LOCK_SETTLE = 16,
   parameter int unsigned LOCK_TO     = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pll_locked,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_sel,
   input  logic              req_dir,
   input  logic [STEP_W-1:0] req_steps,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              pll_ready,
   output logic [1:0]        phasesel,
   output logic              phasedir,
   output logic              phasestep,
   output logic              phaseloadreg
);

   // One shared down-counter times every phase; sized for the longest one.
   localparam int unsigned TMR_MAX = max_of(max_of(SETUP_CYC, PULSE_CYC), max_of(GAP_CYC, LOCK_TO));
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] LD_PULSE = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] LD_GAP   = TMR_W'(GAP_CYC - 1);
   localparam logic [TMR_W-1:0] LD_LOCK  = TMR_W'(LOCK_TO - 1);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [STEP_W-1:0]   rem_q, rem_d;
   logic [1:0]          sel_q, sel_d;
   logic                dir_q, dir_d;
   logic                err_q, err_d;
   logic                tmr_tc;

   pll_lock_sync #(
      .LOCK_SETTLE (LOCK_SETTLE)
   ) u_lock_sync (
      .clock      (clock),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .pll_ready  (pll_ready)
   );

   assign tmr_tc = (tmr_q == '0);

   // State, timer and latched request fields.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         rem_q   <= '0;
         sel_q   <= SEL_CLKOP;
         dir_q   <= DIR_ADVANCE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   // Next-state sequencing; sel/dir only change on an accepted request.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      dir_d   = dir_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               sel_d = req_sel;
               dir_d = req_dir;
               rem_d = req_steps;
               err_d = 1'b0;
               if (req_steps == '0) begin
                  state_d = ZERO;
               end else begin
                  state_d = SETUP;
                  tmr_d   = LD_SETUP;
               end
            end
         end

         SETUP: begin
            if (tmr_tc) begin
               state_d = PULSE;
               tmr_d   = LD_PULSE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         PULSE: begin
            if (tmr_tc) begin
               state_d = GAP;
               tmr_d   = LD_GAP;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         GAP: begin
            if (tmr_tc) begin
               rem_d = (rem_q != '0) ? rem_q - STEP_W'(1) : '0;
               if (rem_d == '0) begin
                  state_d = RELOCK;
                  tmr_d   = LD_LOCK;
               end else begin
                  state_d = PULSE;
                  tmr_d   = LD_PULSE;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         RELOCK: begin
            if (pll_ready) begin
               err_d   = 1'b0;
               state_d = FINISH;
            end else if (tmr_tc) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         ZERO: begin
            err_d   = 1'b0;
            state_d = FINISH;
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready    = (state_q == IDLE) && pll_ready;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == FINISH);
   assign err          = done && err_q;
   assign phasestep    = (state_q != PULSE);
   assign phasesel     = sel_q;
   assign phasedir     = dir_q;
   assign phaseloadreg = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: randomized requests checked against a cycle-index
// model of the expected PHASESTEP waveform and done timing.
module tb_pll_phase_ctrl;

   localparam int STEP_W = 8;
   localparam int S      = 2;
   localparam int P      = 2;
   localparam int G      = 4;
   localparam int LS     = 16;
   localparam int LTO    = 1024;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              pll_locked;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_sel;
   logic              req_dir;
   logic [STEP_W-1:0] req_steps;
   logic              done;
   logic              err;
   logic              busy;
   logic              pll_ready;
   logic [1:0]        phasesel;
   logic              phasedir;
   logic              phasestep;
   logic              phaseloadreg;

   int checks = 0;
   int errors = 0;

   pll_phase_ctrl #(
      .STEP_W      (STEP_W),
      .SETUP_CYC   (S),
      .PULSE_CYC   (P),
      .GAP_CYC     (G),
      .LOCK_SETTLE (LS),
      .LOCK_TO     (LTO)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sel      (req_sel),
      .req_dir      (req_dir),
      .req_steps    (req_steps),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .pll_ready    (pll_ready),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected PHASESTEP k cycles after the accepting edge for an n-step request.
   function automatic logic model_step(input int k, input int n);
      if (n > 0 && k >= S && k < S + n * (P + G) && ((k - S) % (P + G)) < P)
         return 1'b0;
      return 1'b1;
   endfunction

   // Issues one request and checks the full response against the model.
   // drop_k/restore_k move pll_locked at those cycle indices (-1 = never).
   task automatic run_req(input logic [1:0] sel, input logic dir, input int n,
                          input int drop_k, input int restore_k,
                          input logic exp_err, input string name);
      int   w;
      int   exp_done;
      int   done_k;
      int   done_cnt;
      int   pulses;
      int   trace_bad;
      int   first_bad;
      int   field_bad;
      int   busy_bad;
      logic err_at_done;
      logic prev_step;
      logic exp_busy;

      w = 0;
      while (!req_ready && w < 300) begin
         tick();
         w++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: req_ready=%b after %0d cycles, need 1", name, req_ready, w);
         return;
      end

      if (n == 0) exp_done = 1;
      else if (drop_k >= 0 && restore_k < 0) exp_done = S + n * (P + G) + LTO;
      else exp_done = S + n * (P + G) + 1;
      if (restore_k >= 0 && restore_k + 2 + LS + 1 > exp_done) exp_done = restore_k + 2 + LS + 1;

      req_sel   = sel;
      req_dir   = dir;
      req_steps = STEP_W'(n);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_sel   = ~sel;
      req_dir   = ~dir;
      req_steps = STEP_W'($urandom);

      done_k = -1; done_cnt = 0; pulses = 0; trace_bad = 0; first_bad = -1;
      field_bad = 0; busy_bad = 0; err_at_done = 1'bx; prev_step = 1'b1;

      for (int k = 0; k <= exp_done + 1; k++) begin
         if (k == drop_k) pll_locked = 1'b0;
         if (k == restore_k) pll_locked = 1'b1;
         if (phasestep !== model_step(k, n)) begin
            trace_bad++;
            if (first_bad < 0) first_bad = k;
         end
         if (phasesel !== sel || phasedir !== dir || phaseloadreg !== 1'b1) field_bad++;
         exp_busy = (k <= exp_done);
         if (busy !== exp_busy) busy_bad++;
         if (done === 1'b1) begin
            if (done_k < 0) begin
               done_k      = k;
               err_at_done = err;
            end
            done_cnt++;
         end
         if (prev_step === 1'b1 && phasestep === 1'b0) pulses++;
         prev_step = phasestep;
         if (k <= exp_done) tick();
      end

      checks++;
      if (done_k != exp_done) begin
         errors++;
         $display("FAIL %s done_time: done at cycle %0d, need %0d", name, done_k, exp_done);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_count: %0d done cycles, need 1", name, done_cnt);
      end
      checks++;
      if (err_at_done !== exp_err) begin
         errors++;
         $display("FAIL %s err: got %b, need %b", name, err_at_done, exp_err);
      end
      checks++;
      if (pulses != n) begin
         errors++;
         $display("FAIL %s pulse_count: got %0d, need %0d", name, pulses, n);
      end
      checks++;
      if (trace_bad != 0) begin
         errors++;
         $display("FAIL %s phasestep_trace: %0d bad cycles, first at %0d, need 0", name, trace_bad, first_bad);
      end
      checks++;
      if (field_bad != 0) begin
         errors++;
         $display("FAIL %s sel_dir_hold: %0d bad cycles, need 0 (sel=%b dir=%b)", name, field_bad, sel, dir);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy: %0d bad cycles, need 0", name, busy_bad);
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      req_valid  = 1'b0;
      req_sel    = 2'b00;
      req_dir    = 1'b0;
      req_steps  = '0;
      repeat (3) tick();
      checks++;
      if (phasesel !== 2'b11) begin
         errors++;
         $display("FAIL reset_phasesel: got %b, need 11", phasesel);
      end
      checks++;
      if ({phasedir, phasestep, phaseloadreg} !== 3'b111) begin
         errors++;
         $display("FAIL reset_phase_pins: dir/step/loadreg=%b, need 111", {phasedir, phasestep, phaseloadreg});
      end
      checks++;
      if ({req_ready, done, err, busy, pll_ready} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_status: ready/done/err/busy/pll_ready=%b, need 00000",
                  {req_ready, done, err, busy, pll_ready});
      end
      reset_n = 1'b1;
      tick();
   endtask

   // Lock rises; a request held during settling must be ignored.
   task automatic test_lock_settle();
      int rise_c;
      int early_busy;
      int bad_idle;
      rise_c = -1; early_busy = 0; bad_idle = 0;
      pll_locked = 1'b1;
      req_sel    = 2'b10;
      req_dir    = 1'b0;
      req_steps  = 8'd3;
      req_valid  = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (busy !== 1'b0) early_busy++;
         if (phasestep !== 1'b1 || phaseloadreg !== 1'b1) bad_idle++;
         if (pll_ready === 1'b1) begin
            rise_c    = c;
            req_valid = 1'b0;
            break;
         end
      end
      req_valid = 1'b0;
      checks++;
      if (rise_c != LS + 2) begin
         errors++;
         $display("FAIL lock_latency: pll_ready after %0d cycles, need %0d", rise_c, LS + 2);
      end
      checks++;
      if (early_busy != 0) begin
         errors++;
         $display("FAIL ignore_unready_req: busy in %0d cycles, need 0", early_busy);
      end
      checks++;
      if (bad_idle != 0) begin
         errors++;
         $display("FAIL idle_pins: %0d bad cycles, need 0", bad_idle);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_when_locked: got %b, need 1", req_ready);
      end
   endtask

   task automatic test_basic();
      run_req(2'b01, 1'b1, 3, -1, -1, 1'b0, "basic");
   endtask

   task automatic test_zero();
      run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, -1, -1, 1'b0, "zero");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), -1, -1, 1'b0, "random");
   endtask

   task automatic test_lock_loss();
      run_req(2'b10, 1'b0, 2, S + P, S + P + 50, 1'b0, "lock_loss");
   endtask

   task automatic test_relock_timeout();
      run_req(2'b00, 1'b1, 1, S + P, -1, 1'b1, "timeout");
      pll_locked = 1'b1;
   endtask

   task automatic test_reset_mid();
      int w;
      int done_seen;
      w = 0;
      while (!req_ready && w < 300) begin
         tick();
         w++;
      end
      req_sel   = 2'b01;
      req_dir   = 1'b0;
      req_steps = 8'd5;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (phasestep !== 1'b0) begin
         errors++;
         $display("FAIL midreset_in_pulse: phasestep=%b, need 0", phasestep);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({phasestep, busy, done, phasesel} !== 5'b10011) begin
         errors++;
         $display("FAIL midreset_async: step/busy/done/sel=%b, need 10011", {phasestep, busy, done, phasesel});
      end
      done_seen = 0;
      repeat (3) begin
         tick();
         if (done !== 1'b0) done_seen++;
      end
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done !== 1'b0) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL midreset_no_done: done seen %0d cycles, need 0", done_seen);
      end
      run_req(2'b11, 1'b1, 4, -1, -1, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_lock_settle();
      test_basic();
      test_zero();
      test_back_to_back();
      test_lock_loss();
      test_relock_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
